alu_exc_ctrl: RTL and testbench
===============================

# alu_exc_ctrl

Arithmetic exception controller at the consuming end of the ALU's `overflow` flag. It samples the EX-stage ALU status each cycle and, on a trapping overflow, flushes the pipeline, records EPC and Cause, and redirects fetch to the exception vector. It holds the exception level (EXL) until an ERET arrives, then redirects fetch back past the faulting instruction. It sits beside the ALU in EX and drives the PC-select and flush logic.

## Interface
- `PC_W`, 32, PC/EPC width.
- `VECTOR`, 32'h8000_0180, handler entry address.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `ex_valid`  in  1  EX-stage instruction is valid (not a bubble).
- `ex_op`  in  3  ALU op of the EX instruction, same encoding as ALU `op`.
- `ex_trap_en`  in  1  instruction traps on overflow (add/sub = 1, addu/subu = 0).
- `ex_overflow`  in  1  ALU overflow flag for the EX instruction.
- `ex_pc`  in  PC_W  PC of the EX instruction.
- `ex_eret`  in  1  EX instruction is ERET.
- `flush`  out  1  kill IF/ID/EX contents; one-cycle pulse.
- `redirect`  out  1  fetch takes `redirect_pc`; one-cycle pulse, coincident with `flush`.
- `redirect_pc`  out  PC_W  target address for fetch.
- `epc`  out  PC_W  PC of the last trapping instruction.
- `cause`  out  5  exception code (12 = Ov, 10 = RI).
- `exl`  out  1  exception level; 1 while the handler runs.
- `trap_count`  out  8  saturating count of traps taken.

## Operation
- The FSM has three states: IDLE, TRAP, HANDLER.
- Trap condition `hit` = `ex_valid & ex_trap_en & ex_overflow & ~exl`. In addition, `ex_op` must be 3'b010 or 3'b110.
- IDLE: on `hit`, go to TRAP. On the same edge, latch `epc <= ex_pc` and `cause <= 12`, and set `exl <= 1`.
- TRAP: `flush = redirect = 1` and `redirect_pc = VECTOR`. Increment `trap_count`, which saturates at 255. Go to HANDLER unconditionally.
- HANDLER: `exl = 1`. Overflows are ignored and do not change `epc`, `cause` or `trap_count`. On `ex_valid & ex_eret`, pulse `flush = redirect = 1` for one cycle with `redirect_pc = epc + 4` (mod 2^PC_W), clear `exl`, and go to IDLE.
- ERET while in IDLE: ignored, no pulse.
- Overflow and ERET in the same HANDLER cycle: ERET wins and the overflow is dropped.
- `ex_valid = 0` masks every input.
- `redirect_pc` holds its last value when `redirect = 0`.
- Reset values: state IDLE; `flush`, `redirect`, `exl` = 0; `epc`, `redirect_pc` = 0; `cause` = 0; `trap_count` = 0. Reset mid-TRAP or mid-HANDLER aborts with no pulse in the following cycle.

## Timing
- All inputs are sampled at the rising edge. All outputs are registered.
- Trap latency: faulting instruction sampled at edge N → `flush`/`redirect` high during cycle N+1 → `exl = 1` visible from N+1.
- ERET latency: ERET sampled at edge M → pulse during M+1 → `exl = 0` from M+1.
- Minimum spacing between two traps is 3 cycles: TRAP, HANDLER with ERET, then IDLE.
- `epc` and `cause` are stable from cycle N+1 until the next trap.

## Configuration
- `ALU_BADOP_EXC_EN` defined:
  - `ex_valid & ~exl` with `ex_op` ∈ {3'b011, 3'b111} also enters TRAP, with `cause <= 10` and `epc <= ex_pc`. This applies regardless of `ex_trap_en`.
  - If bad-op and overflow are both true in the same cycle, RI has priority.
- Macro undefined:
  - Undefined ops are ignored; only Ov traps exist.
  - `cause` can only hold 0 or 12.

## Structure
- Package `alu_exc_pkg`: state enum (IDLE, TRAP, HANDLER), cause constants `EXC_OV = 5'd12` and `EXC_RI = 5'd10`, ALU op constants `OP_ADD = 3'b010` and `OP_SUB = 3'b110`, default `VECTOR`.
- Sub-module `sat_counter` (parameterised width, increment enable, synchronous reset) implements `trap_count`. Everything else lives in the top-level FSM.

## Test plan
- Trap: ex_valid=1, op=010, trap_en=1, overflow=1, pc=0x0040_0010 → next cycle flush=redirect=1, redirect_pc=0x8000_0180, epc=0x0040_0010, cause=12, exl=1, trap_count=1.
- Unsigned add: overflow=1, trap_en=0, op=010 → no pulse, exl=0, epc unchanged.
- Return: after a trap, ERET with ex_valid=1 → one-cycle pulse, redirect_pc=0x0040_0014, exl=0. A second ERET in IDLE gives no pulse.
- Nested/simultaneous: in HANDLER, overflow plus ERET in the same cycle → ERET pulse only, trap_count unchanged, epc unchanged.
- Reset mid-HANDLER: assert reset for 1 cycle → all outputs 0, state IDLE, and a following ERET is ignored.
- Saturation / bad op: run 300 trap/ERET loops → trap_count=255. With ALU_BADOP_EXC_EN, op=111 plus overflow=1 → cause=10; without the macro, op=111 → no trap.

Source files
------------

// File: rtl/alu_exc_pkg.sv
// alu_exc_pkg: shared types and constants for the arithmetic exception
// controller.
//   state_t          controller states (IDLE, TRAP, HANDLER)
//   EXC_OV / EXC_RI  cause codes for overflow and reserved instruction
//   OP_*             ALU op encodings the controller decodes
//   VECTOR_DEFAULT   default handler entry address
package alu_exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRAP    = 2'd1,
    HANDLER = 2'd2
  } state_t;

  localparam logic [4:0] EXC_OV = 5'd12;
  localparam logic [4:0] EXC_RI = 5'd10;

  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_BAD0 = 3'b011;
  localparam logic [2:0] OP_BAD1 = 3'b111;

  localparam logic [31:0] VECTOR_DEFAULT = 32'h8000_0180;

  // Only signed add/sub can raise a trapping overflow.
  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Encodings the ALU does not implement.
  function automatic logic is_bad_op(input logic [2:0] op);
    return (op == OP_BAD0) || (op == OP_BAD1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value.
//   clock  rising-edge clock
//   reset  synchronous, active-high; clears count
//   inc    add one this cycle (ignored once saturated)
//   count  current value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/alu_exc_ctrl.sv
// alu_exc_ctrl: arithmetic exception controller in the EX stage.
// Samples ALU status each cycle; on a trapping overflow it flushes the
// pipeline, records EPC/Cause, raises EXL and redirects fetch to VECTOR.
// An ERET while the handler runs redirects fetch to EPC+4 and drops EXL.
//
// Build option: ALU_BADOP_EXC_EN -- when defined, undefined ALU ops
// (3'b011, 3'b111) also trap with cause RI, taking priority over Ov.
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   ex_valid               EX instruction is real (0 masks all other inputs)
//   ex_op, ex_trap_en      ALU op and "traps on overflow" flag
//   ex_overflow, ex_pc     ALU overflow flag and PC of the EX instruction
//   ex_eret                EX instruction is ERET
//   flush, redirect        one-cycle pulses, always coincident
//   redirect_pc            fetch target; holds when redirect is low
//   epc, cause             PC and code of the last trap taken
//   exl                    exception level, high while the handler runs
//   trap_count             saturating count of traps taken
module alu_exc_ctrl
  import alu_exc_pkg::*;
#(
  parameter int              PC_W   = 32,
  parameter logic [PC_W-1:0] VECTOR = VECTOR_DEFAULT[PC_W-1:0]
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [2:0]      ex_op,
  input  logic            ex_trap_en,
  input  logic            ex_overflow,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_eret,
  output logic            flush,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] epc,
  output logic [4:0]      cause,
  output logic            exl,
  output logic [7:0]      trap_count
);

  state_t state;
  logic   hit_ov;
  logic   hit_bad;
  logic   take;

  assign hit_ov = ex_valid & ex_trap_en & ex_overflow & ~exl & is_arith_op(ex_op);

`ifdef ALU_BADOP_EXC_EN
  assign hit_bad = ex_valid & ~exl & is_bad_op(ex_op);
`else
  assign hit_bad = 1'b0;
`endif

  // Traps are only accepted from IDLE; TRAP and HANDLER drop them.
  assign take = (state == IDLE) & (hit_ov | hit_bad);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      epc         <= '0;
      cause       <= '0;
      exl         <= 1'b0;
    end else begin
      // Pulses default low; redirect_pc keeps its last target.
      flush    <= 1'b0;
      redirect <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            state       <= TRAP;
            flush       <= 1'b1;
            redirect    <= 1'b1;
            redirect_pc <= VECTOR;
            epc         <= ex_pc;
            cause       <= hit_bad ? EXC_RI : EXC_OV;
            exl         <= 1'b1;
          end
        end
        TRAP: begin
          // Pulse is visible this cycle; ERET here is too early to honour.
          state <= HANDLER;
        end
        HANDLER: begin
          // ERET wins over any overflow presented in the same cycle.
          if (ex_valid && ex_eret) begin
            state       <= IDLE;
            flush       <= 1'b1;
            redirect    <= 1'b1;
            redirect_pc <= epc + PC_W'(4);
            exl         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.W(8)) u_trap_count (
    .clock (clock),
    .reset (reset),
    .inc   (take),
    .count (trap_count)
  );

endmodule

// File: tb/tb_alu_exc_ctrl.sv
// tb_alu_exc_ctrl: directed-vector bench for alu_exc_ctrl with a
// behavioural reference model compared every cycle and literal
// expectations at key points of the sequence.
module tb_alu_exc_ctrl;

  localparam logic [31:0] VEC = 32'h8000_0180;
`ifdef ALU_BADOP_EXC_EN
  localparam bit BADOP = 1'b1;
`else
  localparam bit BADOP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic        ex_trap_en;
  logic        ex_overflow;
  logic [31:0] ex_pc;
  logic        ex_eret;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic [4:0]  cause;
  logic        exl;
  logic [7:0]  trap_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  alu_exc_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .ex_op       (ex_op),
    .ex_trap_en  (ex_trap_en),
    .ex_overflow (ex_overflow),
    .ex_pc       (ex_pc),
    .ex_eret     (ex_eret),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .epc         (epc),
    .cause       (cause),
    .exl         (exl),
    .trap_count  (trap_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: exception level, a "pulse just went out for a trap"
  // flag (ERET is not honoured in that cycle), and the architectural regs.
  bit          m_exl, m_trap_cycle, m_pulse;
  logic [31:0] m_rpc, m_epc;
  logic [4:0]  m_cause;
  int          m_count;

  always @(posedge clock) begin
    bit bad, ov, trap, eret;
    if (reset) begin
      m_exl <= 0; m_trap_cycle <= 0; m_pulse <= 0;
      m_rpc <= 0; m_epc <= 0; m_cause <= 0; m_count <= 0;
    end else begin
      bad  = BADOP && ex_valid && !m_exl && (ex_op == 3'd3 || ex_op == 3'd7);
      ov   = ex_valid && !m_exl && ex_trap_en && ex_overflow && (ex_op == 3'd2 || ex_op == 3'd6);
      trap = bad || ov;
      eret = ex_valid && ex_eret && m_exl && !m_trap_cycle;
      m_pulse      <= trap || eret;
      m_trap_cycle <= trap;
      if (trap) begin
        m_exl   <= 1;
        m_epc   <= ex_pc;
        m_cause <= bad ? 5'd10 : 5'd12;
        m_count <= (m_count < 255) ? m_count + 1 : 255;
        m_rpc   <= VEC;
      end
      if (eret) begin
        m_exl <= 0;
        m_rpc <= m_epc + 32'd4;
      end
    end
  end

  // Compare process: every cycle once reset has been applied.
  always @(negedge clock) begin
    if (chk_en) begin
      check("model_flush",       {31'd0, flush},       {31'd0, m_pulse});
      check("model_redirect",    {31'd0, redirect},    {31'd0, m_pulse});
      check("model_redirect_pc", redirect_pc,          m_rpc);
      check("model_epc",         epc,                  m_epc);
      check("model_cause",       {27'd0, cause},       {27'd0, m_cause});
      check("model_exl",         {31'd0, exl},         {31'd0, m_exl});
      check("model_trap_count",  {24'd0, trap_count},  m_count);
    end
  end

  task automatic cyc(input bit v, input logic [2:0] op, input bit te, input bit ov,
                     input logic [31:0] pc, input bit er);
    ex_valid = v; ex_op = op; ex_trap_en = te; ex_overflow = ov; ex_pc = pc; ex_eret = er;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    cyc(0, 3'd0, 0, 0, 32'd0, 0);
  endtask

  initial begin
    reset = 1'b1;
    ex_valid = 0; ex_op = 0; ex_trap_en = 0; ex_overflow = 0; ex_pc = 0; ex_eret = 0;
    @(posedge clock);
    chk_en = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Reset state
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_exl",   {31'd0, exl},   32'd0);
    check("rst_epc",   epc,            32'd0);
    check("rst_count", {24'd0, trap_count}, 32'd0);

    // Signed add overflow traps
    cyc(1, 3'b010, 1, 1, 32'h0040_0010, 0);
    check("trap_flush",    {31'd0, flush},    32'd1);
    check("trap_redirect", {31'd0, redirect}, 32'd1);
    check("trap_rpc",      redirect_pc,       32'h8000_0180);
    check("trap_epc",      epc,               32'h0040_0010);
    check("trap_cause",    {27'd0, cause},    32'd12);
    check("trap_exl",      {31'd0, exl},      32'd1);
    check("trap_count",    {24'd0, trap_count}, 32'd1);
    idle();
    check("handler_flush", {31'd0, flush}, 32'd0);
    check("handler_rpc_hold", redirect_pc, 32'h8000_0180);

    // ERET returns past the faulting instruction
    cyc(1, 3'b000, 0, 0, 32'h8000_0184, 1);
    check("eret_flush", {31'd0, flush}, 32'd1);
    check("eret_rpc",   redirect_pc,    32'h0040_0014);
    check("eret_exl",   {31'd0, exl},   32'd0);
    cyc(1, 3'b000, 0, 0, 32'h0040_0014, 1);
    check("eret_idle_flush", {31'd0, flush}, 32'd0);

    // Unsigned add, wrong op, and masked valid: no trap
    cyc(1, 3'b010, 0, 1, 32'h0000_1234, 0);
    check("unsigned_flush", {31'd0, flush}, 32'd0);
    check("unsigned_epc",   epc,            32'h0040_0010);
    cyc(1, 3'b000, 1, 1, 32'h0000_2000, 0);
    check("otherop_exl", {31'd0, exl}, 32'd0);
    cyc(0, 3'b110, 1, 1, 32'h0000_3000, 1);
    check("masked_flush", {31'd0, flush}, 32'd0);

    // Subtract trap, ERET in TRAP cycle ignored, then ERET+overflow in HANDLER
    cyc(1, 3'b110, 1, 1, 32'h0000_0100, 0);
    cyc(1, 3'b000, 0, 0, 32'h0000_0104, 1);
    check("eret_in_trap_flush", {31'd0, flush}, 32'd0);
    check("eret_in_trap_exl",   {31'd0, exl},   32'd1);
    cyc(1, 3'b010, 1, 1, 32'h0000_0200, 1);
    check("simul_flush", {31'd0, flush},      32'd1);
    check("simul_rpc",   redirect_pc,         32'h0000_0104);
    check("simul_epc",   epc,                 32'h0000_0100);
    check("simul_count", {24'd0, trap_count}, 32'd2);

    // Reset mid-HANDLER
    cyc(1, 3'b010, 1, 1, 32'h0000_0300, 0);
    idle();
    reset = 1'b1;
    idle();
    reset = 1'b0;
    check("midrst_flush", {31'd0, flush}, 32'd0);
    check("midrst_exl",   {31'd0, exl},   32'd0);
    check("midrst_epc",   epc,            32'd0);
    check("midrst_rpc",   redirect_pc,    32'd0);
    check("midrst_count", {24'd0, trap_count}, 32'd0);
    cyc(1, 3'b000, 0, 0, 32'h0000_0304, 1);
    check("midrst_eret_flush", {31'd0, flush}, 32'd0);

    // Undefined op with overflow
    cyc(1, 3'b111, 1, 1, 32'h0000_0500, 0);
    if (BADOP) begin
      check("badop_cause", {27'd0, cause}, 32'd10);
      check("badop_flush", {31'd0, flush}, 32'd1);
    end else begin
      check("badop_cause", {27'd0, cause}, 32'd0);
      check("badop_flush", {31'd0, flush}, 32'd0);
    end
    idle();
    cyc(1, 3'b000, 0, 0, 32'h0, 1);

    // EPC+4 wraps modulo 2^32
    cyc(1, 3'b010, 1, 1, 32'hFFFF_FFFC, 0);
    idle();
    cyc(1, 3'b000, 0, 0, 32'h0, 1);
    check("wrap_rpc", redirect_pc, 32'h0000_0000);

    // Back-to-back trap/ERET loops drive the counter into saturation
    for (int i = 0; i < 300; i++) begin
      cyc(1, (i % 2 == 0) ? 3'b010 : 3'b110, 1, 1, 32'h0001_0000 + 32'(i * 4), 0);
      idle();
      cyc(1, 3'b000, 0, 0, 32'h0, 1);
    end
    idle();
    check("sat_count", {24'd0, trap_count}, 32'd255);
    check("sat_epc",   epc, 32'h0001_0000 + 32'd299 * 32'd4);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
